// File: rtl/branch_feedback_unit_pkg.sv
// Shared definitions for the branch feedback unit: default widths,
// boolean constants, counter type and the saturating increment.
package branch_feedback_unit_pkg;

    localparam int BFU_ADDR_W = 32;
    localparam int BFU_IDX_W  = 8;
    localparam int BFU_DEPTH  = 4;
    localparam int CNT_W      = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    // Update entry layout inside the FIFO, MSB first:
    //   {index[IDX_W-1:0], real_jump, target[ADDR_W-1:0]}
    function automatic int entry_width(int addr_w, int idx_w);
        return idx_w + 1 + addr_w;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(cnt_t c);
        return (&c) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/branch_feedback_unit_if.sv
// Commit-side and predictor-side signals of the branch feedback unit.
// master = ROB/predictor/front-end environment, slave = the unit.
interface branch_feedback_unit_if
    import branch_feedback_unit_pkg::*;
#(
    parameter int ADDR_W = BFU_ADDR_W,
    parameter int IDX_W  = BFU_IDX_W
) ();
    logic              commit_valid;
    logic              commit_is_branch;
    logic [ADDR_W-1:0] commit_pc;
    logic              commit_predicted_jump;
    logic              commit_real_jump;
    logic [ADDR_W-1:0] commit_target;
    logic              commit_ready;

    logic              pred_stall;
    logic              rob_enable_predictor;
    logic              real_jump_or_not;
    logic [IDX_W-1:0]  instr_pc;
    logic [ADDR_W-1:0] jump_to_pc;

    logic              mispredict_flush;
    logic [ADDR_W-1:0] redirect_pc;
    cnt_t              branch_cnt;
    cnt_t              mispredict_cnt;

    modport master (
        output commit_valid, commit_is_branch, commit_pc, commit_predicted_jump,
               commit_real_jump, commit_target, pred_stall,
        input  commit_ready, rob_enable_predictor, real_jump_or_not, instr_pc,
               jump_to_pc, mispredict_flush, redirect_pc, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  commit_valid, commit_is_branch, commit_pc, commit_predicted_jump,
               commit_real_jump, commit_target, pred_stall,
        output commit_ready, rob_enable_predictor, real_jump_or_not, instr_pc,
               jump_to_pc, mispredict_flush, redirect_pc, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_feedback_unit_sync_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module branch_feedback_unit_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    // Write at tail on push, advance head on pop; overflow/underflow ignored.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push && !full) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_d = rd_q + PTR_ONE;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/branch_feedback_unit.sv
// Branch feedback unit: buffers resolved branches from ROB commit, feeds
// them to the predictor through a one-entry valid/stall output stage,
// pulses a flush with the corrected PC on mispredicts, and keeps
// saturating branch/mispredict statistics.
module branch_feedback_unit
    import branch_feedback_unit_pkg::*;
#(
    parameter int ADDR_W = BFU_ADDR_W,
    parameter int IDX_W  = BFU_IDX_W,
    parameter int DEPTH  = BFU_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    branch_feedback_unit_if.slave  bus
);
    localparam int ENT_W = entry_width(ADDR_W, IDX_W);

    logic             full, empty, push, pop, take, mispredict;
    logic [ENT_W-1:0] din, head;

    logic              vld_q, vld_d;
    logic              real_q, real_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] redir_q, redir_d;
    cnt_t              bcnt_q, bcnt_d;
    cnt_t              mcnt_q, mcnt_d;

    // Space is judged from full alone: a same-cycle pop never makes room.
    assign bus.commit_ready = !full;
    assign push       = rdy && bus.commit_valid && bus.commit_is_branch && !full;
    assign mispredict = bus.commit_predicted_jump != bus.commit_real_jump;
    // Output stage can load when empty or when its entry leaves this edge.
    assign take       = !vld_q || !bus.pred_stall;
    assign pop        = rdy && take && !empty;
    assign din        = {bus.commit_pc[IDX_W+1:2], bus.commit_real_jump, bus.commit_target};

    branch_feedback_unit_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Output stage refill: load FIFO head, or go idle keeping the old fields.
    always_comb begin
        vld_d  = vld_q;
        real_d = real_q;
        idx_d  = idx_q;
        tgt_d  = tgt_q;
        if (rdy && take) begin
            vld_d = !empty;
            if (!empty) begin
                {idx_d, real_d, tgt_d} = head;
            end
        end
    end

    // Flush pulse, redirect target and statistics, all updated on accept.
    always_comb begin
        flush_d = flush_q;
        redir_d = redir_q;
        bcnt_d  = bcnt_q;
        mcnt_d  = mcnt_q;
        if (rdy) begin
            flush_d = FALSE;
            if (push) begin
                bcnt_d = sat_inc(bcnt_q);
                if (mispredict) begin
                    flush_d = TRUE;
                    redir_d = bus.commit_real_jump ? bus.commit_target
                                                   : bus.commit_pc + ADDR_W'(4);
                    mcnt_d  = sat_inc(mcnt_q);
                end
            end
        end
    end

    // State registers; reset discards any in-flight update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= FALSE;
            real_q  <= FALSE;
            idx_q   <= '0;
            tgt_q   <= '0;
            flush_q <= FALSE;
            redir_q <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            real_q  <= real_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            flush_q <= flush_d;
            redir_q <= redir_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign bus.rob_enable_predictor = vld_q;
    assign bus.real_jump_or_not     = real_q;
    assign bus.instr_pc             = idx_q;
    assign bus.jump_to_pc           = tgt_q;
    assign bus.mispredict_flush     = flush_q;
    assign bus.redirect_pc          = redir_q;
    assign bus.branch_cnt           = bcnt_q;
    assign bus.mispredict_cnt       = mcnt_q;

endmodule

// File: tb/tb_branch_feedback_unit.sv
// Directed bench for branch_feedback_unit: a table of single-edge vectors
// followed by hand-written stall, reset, back-to-back flush and
// saturation sequences.
module tb_branch_feedback_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    branch_feedback_unit_if #(.ADDR_W(32), .IDX_W(8)) bus ();

    branch_feedback_unit #(.ADDR_W(32), .IDX_W(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    typedef struct {
        logic        v, br;
        logic [31:0] pc;
        logic        pj, rj;
        logic [31:0] tgt;
        logic        stall, r;
        logic        en, rjo;
        logic [7:0]  idx;
        logic [31:0] jto;
        logic        fl;
        logic [31:0] rpc;
        logic        crdy;
        logic [31:0] bc, mc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic v, logic br, logic [31:0] pc, logic pj, logic rj,
                                logic [31:0] tgt, logic r, logic en, logic rjo,
                                logic [7:0] idx, logic [31:0] jto, logic fl,
                                logic [31:0] rpc, logic [31:0] bc, logic [31:0] mc);
        vec_t x;
        x.v = v; x.br = br; x.pc = pc; x.pj = pj; x.rj = rj; x.tgt = tgt;
        x.stall = 1'b0; x.r = r; x.en = en; x.rjo = rjo; x.idx = idx; x.jto = jto;
        x.fl = fl; x.rpc = rpc; x.crdy = 1'b1; x.bc = bc; x.mc = mc;
        return x;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic br, logic [31:0] pc, logic pj, logic rj,
                         logic [31:0] tgt, logic stall, logic r);
        bus.commit_valid          = v;
        bus.commit_is_branch      = br;
        bus.commit_pc             = pc;
        bus.commit_predicted_jump = pj;
        bus.commit_real_jump      = rj;
        bus.commit_target         = tgt;
        bus.pred_stall            = stall;
        rdy                       = r;
    endtask

    task automatic chk_all(string t, logic en, logic rjo, logic [7:0] idx, logic [31:0] jto,
                           logic fl, logic [31:0] rpc, logic crdy, logic [31:0] bc,
                           logic [31:0] mc);
        chk({t, ".en"},    64'(bus.rob_enable_predictor), 64'(en));
        chk({t, ".real"},  64'(bus.real_jump_or_not),     64'(rjo));
        chk({t, ".idx"},   64'(bus.instr_pc),             64'(idx));
        chk({t, ".jto"},   64'(bus.jump_to_pc),           64'(jto));
        chk({t, ".flush"}, 64'(bus.mispredict_flush),     64'(fl));
        chk({t, ".rpc"},   64'(bus.redirect_pc),          64'(rpc));
        chk({t, ".crdy"},  64'(bus.commit_ready),         64'(crdy));
        chk({t, ".bcnt"},  64'(bus.branch_cnt),           64'(bc));
        chk({t, ".mcnt"},  64'(bus.mispredict_cnt),       64'(mc));
    endtask

    initial begin
        logic pending;
        logic acc;

        //               v br pc            pj rj tgt        rdy en rjo idx    jto        fl rpc        bc mc
        vecs[0]  = mk(1, 1, 32'h0000_1000, 1, 1, 32'h1040, 1, 0, 0, 8'h00, 32'h0,    0, 32'h0,    1, 0);
        vecs[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 1, 8'h00, 32'h1040, 0, 32'h0,    1, 0);
        vecs[2]  = mk(0, 0, 32'h0,         0, 0, 32'h0,    1, 0, 1, 8'h00, 32'h1040, 0, 32'h0,    1, 0);
        vecs[3]  = mk(1, 1, 32'h0000_2004, 1, 0, 32'h2100, 1, 0, 1, 8'h00, 32'h1040, 1, 32'h2008, 2, 1);
        vecs[4]  = mk(1, 1, 32'h0000_2010, 0, 1, 32'h3000, 1, 1, 0, 8'h01, 32'h2100, 1, 32'h3000, 3, 2);
        vecs[5]  = mk(1, 0, 32'h0000_5000, 1, 0, 32'h0,    1, 1, 1, 8'h04, 32'h3000, 0, 32'h3000, 3, 2);
        vecs[6]  = mk(1, 1, 32'h0000_040C, 0, 0, 32'h0500, 1, 0, 1, 8'h04, 32'h3000, 0, 32'h3000, 4, 2);
        vecs[7]  = mk(1, 1, 32'h0000_0600, 1, 0, 32'h0700, 0, 0, 1, 8'h04, 32'h3000, 0, 32'h3000, 4, 2);
        vecs[8]  = vecs[7];
        vecs[9]  = vecs[7];
        vecs[10] = mk(0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 0, 8'h03, 32'h0500, 0, 32'h3000, 4, 2);
        vecs[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,    0, 1, 0, 8'h03, 32'h0500, 0, 32'h3000, 4, 2);
        vecs[12] = mk(0, 0, 32'h0,         0, 0, 32'h0,    1, 0, 0, 8'h03, 32'h0500, 0, 32'h3000, 4, 2);
        vecs[13] = mk(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h1234, 1, 0, 0, 8'h03, 32'h0500, 1, 32'h0,    5, 3);
        vecs[14] = mk(0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 0, 8'hFF, 32'h1234, 0, 32'h0,    5, 3);

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk_all("por", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table: inputs applied for one edge, outputs compared after it.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].br, vecs[i].pc, vecs[i].pj, vecs[i].rj,
                  vecs[i].tgt, vecs[i].stall, vecs[i].r);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].rjo, vecs[i].idx,
                    vecs[i].jto, vecs[i].fl, vecs[i].rpc, vecs[i].crdy, vecs[i].bc,
                    vecs[i].mc);
        end

        // Predictor stalled for 10 cycles while 6 branches commit.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'h100 + 32'(4 * i), 1, 1, 32'h8000 + 32'(i), 1, 1);
            chk($sformatf("stall.crdy%0d", i), 64'(bus.commit_ready), 64'd1);
            tick();
        end
        drive(1, 1, 32'h114, 1, 1, 32'h8005, 1, 1);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("stall.full%0d", j), 64'(bus.commit_ready), 64'd0);
            chk($sformatf("stall.en%0d", j),   64'(bus.rob_enable_predictor), 64'd1);
            chk($sformatf("stall.idx%0d", j),  64'(bus.instr_pc), 64'h40);
            tick();
        end
        bus.pred_stall = 1'b0;
        pending = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            acc = pending && bus.commit_ready;
            tick();
            if (acc) begin
                pending = 1'b0;
                bus.commit_valid = 1'b0;
            end
            chk($sformatf("drain.en%0d", k),  64'(bus.rob_enable_predictor), 64'd1);
            chk($sformatf("drain.idx%0d", k), 64'(bus.instr_pc), 64'h40 + 64'(k));
            chk($sformatf("drain.jto%0d", k), 64'(bus.jump_to_pc), 64'h8000 + 64'(k));
        end
        chk("drain.accepted", 64'(pending), 64'd0);
        tick();
        chk("drain.idle", 64'(bus.rob_enable_predictor), 64'd0);
        chk("drain.bcnt", 64'(bus.branch_cnt), 64'd11);

        // Reset mid-traffic: outputs clear before any clock edge.
        drive(1, 1, 32'h2004, 1, 0, 32'h9000, 0, 1);
        tick();
        drive(1, 1, 32'h2008, 1, 0, 32'h9000, 0, 1);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk_all("rst", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst.noupd", 64'(bus.rob_enable_predictor), 64'd0);

        // Back-to-back mispredicts give back-to-back flush pulses.
        drive(1, 1, 32'h2004, 1, 0, 32'h2100, 0, 1);
        tick();
        chk("b2b.fl0",  64'(bus.mispredict_flush), 64'd1);
        chk("b2b.rpc0", 64'(bus.redirect_pc), 64'h2008);
        drive(1, 1, 32'h3000, 0, 1, 32'h7000, 0, 1);
        tick();
        chk("b2b.fl1",  64'(bus.mispredict_flush), 64'd1);
        chk("b2b.rpc1", 64'(bus.redirect_pc), 64'h7000);
        chk("b2b.mcnt", 64'(bus.mispredict_cnt), 64'd2);
        chk("b2b.en",   64'(bus.rob_enable_predictor), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("b2b.fl2",  64'(bus.mispredict_flush), 64'd0);
        chk("b2b.en2",  64'(bus.rob_enable_predictor), 64'd1);

        // Counter saturation from a preloaded near-max state.
        force dut.bcnt_q = 32'hFFFF_FFFE;
        force dut.mcnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.bcnt_q;
        release dut.mcnt_q;
        for (int s = 0; s < 2; s++) begin
            drive(1, 1, 32'h4000, 0, 1, 32'h4400, 0, 1);
            tick();
            chk($sformatf("sat.bcnt%0d", s), 64'(bus.branch_cnt), 64'hFFFF_FFFF);
            chk($sformatf("sat.mcnt%0d", s), 64'(bus.mispredict_cnt), 64'hFFFF_FFFF);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
